cpu_core_p: RTL and testbench
=============================

Name: cpu_core_p

Overview:
Parametrised multicycle core that succeeds the fixed 8-register, 16-bit FT/DC/EX/WB machine. Register count, data width and PC width are parameters. The register file, sequencer and execute logic are merged into one block, and the program store moves outside it on an instruction-memory port. It adds branches, logic ops, HALT, a run/stall input, a retire pulse and a debug register-read port. It sits between the team's instruction ROM and the simulation top.

Parameters:
DATA_W, 16, register/ALU width; legal range 16..32.
NREG, 8, number of general registers; power of two, 2..16.
RA_W, 3, register-index width; must equal log2(NREG).
PC_W, 8, program-counter width; legal range 4..8.
INST_W, 15, instruction width; must equal 4+RA_W+8.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
run  in  1  1 = fetch allowed; 0 = hold in FT.
imem_addr  out  PC_W  instruction address; equals pc.
imem_data  in  INST_W  instruction word; valid 1 cycle after imem_addr.
phase  out  4  one-hot {WB,EX,DC,FT}; 4'b0000 when halted.
pc  out  PC_W  current program counter.
retire  out  1  1-cycle pulse in WB of each completed instruction.
halted  out  1  high once HLT executes.
dbg_sel  in  RA_W  debug register select.
dbg_data  out  DATA_W  combinational read of reg[dbg_sel].

Behaviour:
- Instruction fields: op=[INST_W-1 -: 4]; ra=[7+RA_W -: RA_W]; imm=[7:0]; rb=imm[7 -: RA_W].
- States: FT, DC, EX, WB, HALT.
- Transitions: FT->DC when run=1, else stay in FT. DC->EX->WB unconditional. WB->FT, or WB->HALT if op=HLT. HALT is absorbing until reset.
- FT: imem_addr=pc.
- DC: latch imem_data into ir. Latch A=reg[ra] and B=reg[rb] using the ir fields (read through from imem_data this cycle).
- EX: compute result and next_pc.
- WB: write reg[ra] if the op writes; pc<=next_pc; retire=1.
- Opcodes:
  - 0 MOV: ra<=B.
  - 1 ADD: ra<=A+B, mod 2^DATA_W.
  - 2 SUB: ra<=A-B, mod 2^DATA_W.
  - 3 LDL: ra<={A[DATA_W-1:8],imm}.
  - 4 LDH: ra<=A with bits[15:8] replaced by imm.
  - 5 AND: ra<=A&B.
  - 6 OR: ra<=A|B.
  - 7 JMP: next_pc=imm[PC_W-1:0].
  - 8 JNZ: next_pc=imm if A!=0, else pc+1.
  - 15 HLT: no write, pc unchanged.
  - 9..14 NOP: pc+1, no write.
- next_pc for all non-jump ops = pc+1, wrapping from 2^PC_W-1 to 0.
- Every instruction takes exactly 4 cycles with run=1. Stalls occur only in FT.
- Reset (any state, mid-instruction included): state=FT, pc=0, all registers=0, ir=0, A=B=0, retire=0, halted=0, phase=4'b0001. An in-flight WB in the reset cycle is discarded.
- A write to reg[ra] is visible to the next instruction's DC and to dbg_data in the cycle after WB.
- HALT state: no register or pc updates; run is ignored; retire=0.
- Writes to ra=rb behave normally: the operands are the values latched in DC.

Test Plan:
- Program LDH r0,0; LDL r0,1; LDH r1,0; LDL r1,2; ADD r0,r1; HLT, with run=1 -> r0=0x0003, r1=0x0002. 6 retire pulses; halted rises in cycle 24 after reset release; pc=5.
- SUB underflow: r0=0x0001, r1=0x0002, SUB r0,r1 -> r0=0xFFFF. Repeat with DATA_W=32 -> r0=0xFFFFFFFF.
- Loop: r2=3, r3=0xFFFF; body ADD r2,r3; JNZ r2,body -> body taken twice then falls through. r2=0; 6 retires in the loop.
- run=0 held 10 cycles in FT -> phase stays 4'b0001, pc and registers unchanged, no retire. Release -> resumes with normal 4-cycle cadence.
- Assert reset during EX of ADD r0,r1 -> the next cycle shows pc=0, all registers 0, phase=FT, and no WB write occurs.
- PC wrap with PC_W=4: NOPs from pc=15 -> next pc=0. With NREG=16, write r15 via LDL -> dbg_sel=15 reads the value.

Source files
------------

// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised FT/DC/EX/WB multicycle core with external instruction memory.
module cpu_core_p #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int RA_W   = 3,
    parameter int PC_W   = 8,
    parameter int INST_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [3:0]        phase,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted,
    input  logic [RA_W-1:0]   dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic [2:0] {FT, DC, EX, WB, HALT} state_t;
    state_t state;
    logic [INST_W-1:0] ir;
    logic [DATA_W-1:0] a, b, result, alu;
    logic [DATA_W-1:0] regs [NREG];
    logic [PC_W-1:0] next_pc, npc;
    logic [3:0] op;
    logic [RA_W-1:0] ra, d_ra, d_rb;
    logic [7:0] imm;
    assign op = ir[INST_W-1 -: 4];
    assign ra = ir[7+RA_W -: RA_W];
    assign imm = ir[7:0];
    assign d_ra = imem_data[7+RA_W -: RA_W];
    assign d_rb = imem_data[7 -: RA_W];
    assign imem_addr = pc;
    assign dbg_data = regs[dbg_sel];
    always_comb begin
        alu = op == 4'd0 ? b :
              op == 4'd1 ? a + b :
              op == 4'd2 ? a - b :
              op == 4'd3 ? {a[DATA_W-1:8], imm} :
              op == 4'd4 ? (a & ~DATA_W'(16'hFF00)) | DATA_W'({imm, 8'h00}) :
              op == 4'd5 ? a & b : a | b;
        npc = op == 4'd7 || (op == 4'd8 && a != '0) ? imm[PC_W-1:0] :
              op == 4'hF ? pc : pc + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FT;
            pc <= '0;
            ir <= '0;
            a <= '0;
            b <= '0;
            result <= '0;
            next_pc <= '0;
            retire <= 1'b0;
            halted <= 1'b0;
            phase <= 4'b0001;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                FT: if (run) begin
                    state <= DC;
                    phase <= 4'b0010;
                end
                DC: begin
                    ir <= imem_data;
                    a <= regs[d_ra];
                    b <= regs[d_rb];
                    state <= EX;
                    phase <= 4'b0100;
                end
                EX: begin
                    result <= alu;
                    next_pc <= npc;
                    retire <= 1'b1;
                    state <= WB;
                    phase <= 4'b1000;
                end
                WB: begin
                    if (op <= 4'd6) regs[ra] <= result;
                    pc <= next_pc;
                    retire <= 1'b0;
                    state <= op == 4'hF ? HALT : FT;
                    halted <= op == 4'hF;
                    phase <= op == 4'hF ? 4'b0000 : 4'b0001;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: directed vector bench for cpu_core_p in default and wide/16-reg/PC_W=4 builds.
module tb_cpu_core_p;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0, run0, retire0, halted0;
    logic [7:0] addr0, pc0;
    logic [14:0] data0;
    logic [3:0] phase0;
    logic [2:0] sel0;
    logic [15:0] dbg0;
    logic reset1, run1, retire1, halted1;
    logic [3:0] addr1, pc1, phase1, sel1;
    logic [15:0] data1;
    logic [31:0] dbg1;
    logic [14:0] rom0 [256];
    logic [15:0] rom1 [16];
    int checks = 0, failures = 0, ret0 = 0;

    cpu_core_p dut0 (.clk(clk), .reset(reset0), .run(run0), .imem_addr(addr0), .imem_data(data0),
        .phase(phase0), .pc(pc0), .retire(retire0), .halted(halted0), .dbg_sel(sel0), .dbg_data(dbg0));
    cpu_core_p #(.DATA_W(32), .NREG(16), .RA_W(4), .PC_W(4), .INST_W(16)) dut1 (.clk(clk),
        .reset(reset1), .run(run1), .imem_addr(addr1), .imem_data(data1), .phase(phase1), .pc(pc1),
        .retire(retire1), .halted(halted1), .dbg_sel(sel1), .dbg_data(dbg1));

    always @(posedge clk) begin
        data0 <= rom0[addr0];
        data1 <= rom1[addr1];
    end

    function automatic logic [14:0] e0(input logic [3:0] op, input logic [2:0] ra, input logic [7:0] imm);
        return {op, ra, imm};
    endfunction
    function automatic logic [15:0] e1(input logic [3:0] op, input logic [3:0] ra, input logic [7:0] imm);
        return {op, ra, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        if (retire0) ret0++;
    endtask
    task automatic rd0(input logic [2:0] s, output logic [15:0] v);
        sel0 = s;
        #1;
        v = dbg0;
    endtask
    task automatic rd1(input logic [3:0] s, output logic [31:0] v);
        sel1 = s;
        #1;
        v = dbg1;
    endtask
    task automatic clear0();
        for (int i = 0; i < 256; i++) rom0[i] = e0(4'hF, 3'd0, 8'h00);
    endtask
    task automatic reset_dut0();
        reset0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset0 = 1'b0;
        ret0 = 0;
    endtask
    task automatic run_halt0();
        for (int i = 0; i < 300 && !halted0; i++) step();
        chk("halt_reached", 32'(halted0), 32'd1);
    endtask
    task automatic load_base(input logic [15:0] av, input logic [15:0] bv);
        clear0();
        rom0[0] = e0(4'd4, 3'd0, av[15:8]);
        rom0[1] = e0(4'd3, 3'd0, av[7:0]);
        rom0[2] = e0(4'd4, 3'd1, bv[15:8]);
        rom0[3] = e0(4'd3, 3'd1, bv[7:0]);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  imm;
        logic [15:0] a, b, er0;
        logic [7:0]  epc;
    } vec_t;
    vec_t vt [13];

    initial begin
        logic [15:0] v;
        logic [31:0] w;
        vt[0]  = '{4'd0,  8'h20, 16'h1234, 16'hBEEF, 16'hBEEF, 8'd5};
        vt[1]  = '{4'd1,  8'h20, 16'h8001, 16'h8003, 16'h0004, 8'd5};
        vt[2]  = '{4'd2,  8'h20, 16'h0001, 16'h0002, 16'hFFFF, 8'd5};
        vt[3]  = '{4'd3,  8'h5A, 16'h1234, 16'h0000, 16'h125A, 8'd5};
        vt[4]  = '{4'd4,  8'hC3, 16'h1234, 16'h0000, 16'hC334, 8'd5};
        vt[5]  = '{4'd5,  8'h20, 16'hF0F0, 16'h3CC3, 16'h30C0, 8'd5};
        vt[6]  = '{4'd6,  8'h20, 16'hF0F0, 16'h0F01, 16'hFFF1, 8'd5};
        vt[7]  = '{4'd7,  8'h0A, 16'h1234, 16'h0000, 16'h1234, 8'd10};
        vt[8]  = '{4'd8,  8'h0C, 16'h0001, 16'h0000, 16'h0001, 8'd12};
        vt[9]  = '{4'd8,  8'h0C, 16'h0000, 16'h0000, 16'h0000, 8'd5};
        vt[10] = '{4'd11, 8'h20, 16'h5555, 16'hAAAA, 16'h5555, 8'd5};
        vt[11] = '{4'd1,  8'h00, 16'h4001, 16'h0000, 16'h8002, 8'd5};
        vt[12] = '{4'd2,  8'h00, 16'h7777, 16'h0000, 16'h0000, 8'd5};
        reset0 = 1'b1; reset1 = 1'b1; run0 = 1'b0; run1 = 1'b1; sel0 = '0; sel1 = '0;
        for (int i = 0; i < 16; i++) rom1[i] = e1(4'hF, 4'd0, 8'h00);

        load_base(16'h0001, 16'h0002);
        rom0[4] = e0(4'd1, 3'd0, 8'h20);
        reset_dut0();
        chk("rst_phase", 32'(phase0), 32'h1);
        chk("rst_pc", 32'(pc0), 32'h0);
        chk("rst_halted", 32'(halted0), 32'h0);
        rd0(3'd0, v);
        chk("rst_r0", 32'(v), 32'h0);
        repeat (10) step();
        chk("stall_phase", 32'(phase0), 32'h1);
        chk("stall_pc", 32'(pc0), 32'h0);
        chk("stall_retire", 32'(ret0), 32'h0);
        run0 = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 1) chk("cad_dc", 32'(phase0), 32'h2);
            if (k == 2) chk("cad_ex", 32'(phase0), 32'h4);
            if (k == 3) chk("cad_wb_retire", 32'({phase0, retire0}), 32'h11);
            if (k == 4) chk("cad_ft_pc", 32'({phase0, pc0}), 32'h101);
            if (k == 23) chk("halt_not_yet", 32'(halted0), 32'h0);
        end
        chk("halt_at_24", 32'(halted0), 32'h1);
        chk("halt_phase", 32'(phase0), 32'h0);
        chk("halt_pc", 32'(pc0), 32'h5);
        chk("prog_retires", 32'(ret0), 32'd6);
        rd0(3'd0, v);
        chk("prog_r0", 32'(v), 32'h0003);
        rd0(3'd1, v);
        chk("prog_r1", 32'(v), 32'h0002);
        repeat (3) step();
        chk("halt_absorb", 32'({retire0, pc0}), 32'h5);

        reset_dut0();
        for (int k = 1; k <= 18; k++) step();
        chk("mid_ex_phase", 32'({phase0, pc0}), 32'h404);
        reset0 = 1'b1;
        step();
        chk("midrst_pc", 32'(pc0), 32'h0);
        chk("midrst_phase", 32'(phase0), 32'h1);
        chk("midrst_retire", 32'(retire0), 32'h0);
        rd0(3'd0, v);
        chk("midrst_r0", 32'(v), 32'h0);
        rd0(3'd1, v);
        chk("midrst_r1", 32'(v), 32'h0);
        reset0 = 1'b0;

        clear0();
        rom0[0] = e0(4'd4, 3'd2, 8'h00);
        rom0[1] = e0(4'd3, 3'd2, 8'h03);
        rom0[2] = e0(4'd4, 3'd3, 8'hFF);
        rom0[3] = e0(4'd3, 3'd3, 8'hFF);
        rom0[4] = e0(4'd1, 3'd2, 8'h60);
        rom0[5] = e0(4'd8, 3'd2, 8'h04);
        reset_dut0();
        run_halt0();
        chk("loop_pc", 32'(pc0), 32'h6);
        chk("loop_retires", 32'(ret0), 32'd11);
        rd0(3'd2, v);
        chk("loop_r2", 32'(v), 32'h0);
        rd0(3'd3, v);
        chk("loop_r3", 32'(v), 32'hFFFF);

        for (int i = 0; i < 13; i++) begin
            load_base(vt[i].a, vt[i].b);
            rom0[4] = e0(vt[i].op, 3'd0, vt[i].imm);
            reset_dut0();
            run_halt0();
            rd0(3'd0, v);
            chk($sformatf("vec%0d_r0", i), 32'(v), 32'(vt[i].er0));
            chk($sformatf("vec%0d_pc", i), 32'(pc0), 32'(vt[i].epc));
        end

        rom1[0] = e1(4'd3, 4'd15, 8'hA5);
        rom1[1] = e1(4'd4, 4'd15, 8'h3C);
        rom1[2] = e1(4'd3, 4'd0, 8'h01);
        rom1[3] = e1(4'd3, 4'd1, 8'h02);
        rom1[4] = e1(4'd2, 4'd0, 8'h10);
        rom1[5] = e1(4'd7, 4'd0, 8'h0E);
        rom1[14] = e1(4'd9, 4'd0, 8'h00);
        rom1[15] = e1(4'd12, 4'd0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset1 = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 24) chk("w_pc_jmp", 32'(pc1), 32'd14);
            if (k == 28) chk("w_pc15", 32'(pc1), 32'd15);
        end
        chk("w_pc_wrap", 32'(pc1), 32'd0);
        chk("w_running", 32'({halted1, phase1}), 32'h1);
        rd1(4'd15, w);
        chk("w_r15", w, 32'h0000_3CA5);
        rd1(4'd0, w);
        chk("w_sub32", w, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
